// File: rtl/sand_pkg.sv
// -----------------------------------------------------------------------------
// sand_pkg
// Shared types and constants for the sand spawner.
//   spawner_state_t : stamp sequencer states
//   SAND_CELL       : cell value written for one grain of sand
// -----------------------------------------------------------------------------
package sand_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        DONE
    } spawner_state_t;

    localparam logic SAND_CELL = 1'b1;

endpackage : sand_pkg

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
// Free-running counter 0..DIV-1; tick_o is high for the one cycle in which
// the counter sits at its last value, i.e. the cycle it wraps back to 0.
// Ports:
//   clk_i    in   system clock
//   reset_i  in   asynchronous, active-high reset (counter -> 0)
//   tick_o   out  one-cycle tick every DIV cycles
// -----------------------------------------------------------------------------
module tick_generator #(
    parameter int DIV = 250000
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge
    // values; blocking here would make results depend on process order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule : tick_generator

// File: rtl/sand_spawner.sv
// -----------------------------------------------------------------------------
// sand_spawner
// Cursor-driven sand injector. Moves a brush cursor one cell per step tick
// from the direction buttons and, while place is held, stamps a
// BRUSH_SIZE x BRUSH_SIZE square of sand into the game-state RAM through a
// req/grant handshake shared with the game state controller.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   btn_*_i                 synchronous, debounced button levels
//   grant_i                 controller hands us the RAM write port
//   req_o                   write-port request (REQ and WRITE states)
//   done_o                  one-cycle pulse after the last cell is written
//   wr_ram_ena_o            registered RAM write enable
//   ram_write_address_o     registered RAM address, row-major
//   ram_write_data_o        registered RAM data (sand when writing)
//   cursor_x_o, cursor_y_o  brush top-left cell
// -----------------------------------------------------------------------------
module sand_spawner #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int BRUSH_SIZE     = 4,
    parameter int MOVE_DIV       = 250000
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              btn_up_i,
    input  logic                              btn_down_i,
    input  logic                              btn_left_i,
    input  logic                              btn_right_i,
    input  logic                              btn_place_i,
    input  logic                              grant_i,
    output logic                              req_o,
    output logic                              done_o,
    output logic                              wr_ram_ena_o,
    output logic [ADDR_WIDTH-1:0]             ram_write_address_o,
    output logic [DATA_WIDTH-1:0]             ram_write_data_o,
    output logic [$clog2(ACTIVE_COLUMNS)-1:0] cursor_x_o,
    output logic [$clog2(ACTIVE_ROWS)-1:0]    cursor_y_o
);

    import sand_pkg::*;

    localparam int XW = $clog2(ACTIVE_COLUMNS);
    localparam int YW = $clog2(ACTIVE_ROWS);
    localparam int BW = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;

    // Largest top-left position that keeps the whole brush on the field;
    // this is what keeps every generated address in range.
    localparam logic [XW-1:0] X_MAX   = XW'(ACTIVE_COLUMNS - BRUSH_SIZE);
    localparam logic [YW-1:0] Y_MAX   = YW'(ACTIVE_ROWS - BRUSH_SIZE);
    localparam logic [XW-1:0] X_RESET = XW'(ACTIVE_COLUMNS / 2);
    localparam logic [YW-1:0] Y_RESET = YW'(ACTIVE_ROWS / 2);
    localparam logic [BW-1:0] B_LAST  = BW'(BRUSH_SIZE - 1);

    logic tick;

    tick_generator #(
        .DIV (MOVE_DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_o  (tick)
    );

    spawner_state_t              state_q, state_d;
    logic [XW-1:0]               cursor_x_q, cursor_x_d;
    logic [YW-1:0]               cursor_y_q, cursor_y_d;
    logic [XW-1:0]               sx_q, sx_d;
    logic [YW-1:0]               sy_q, sy_d;
    logic [BW-1:0]               bx_q, bx_d;
    logic [BW-1:0]               by_q, by_d;
    logic                        wr_ena_q, wr_ena_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        done_q, done_d;
    logic [ADDR_WIDTH-1:0]       cell_addr;

    // ---------------------------------------------------------------- cursor
    // Opposing buttons cancel; movement saturates at the field edges.
    always_comb begin
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        if (tick) begin
            if (btn_right_i && !btn_left_i && (cursor_x_q < X_MAX)) begin
                cursor_x_d = cursor_x_q + XW'(1);
            end else if (btn_left_i && !btn_right_i && (cursor_x_q != '0)) begin
                cursor_x_d = cursor_x_q - XW'(1);
            end
            if (btn_down_i && !btn_up_i && (cursor_y_q < Y_MAX)) begin
                cursor_y_d = cursor_y_q + YW'(1);
            end else if (btn_up_i && !btn_down_i && (cursor_y_q != '0)) begin
                cursor_y_d = cursor_y_q - YW'(1);
            end
        end
    end

    // Row-major address of the brush cell currently being written.
    assign cell_addr = (ADDR_WIDTH'(sy_q) + ADDR_WIDTH'(by_q)) * ADDR_WIDTH'(ACTIVE_COLUMNS)
                     + (ADDR_WIDTH'(sx_q) + ADDR_WIDTH'(bx_q));

    // ------------------------------------------------------------------- FSM
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        bx_d     = bx_q;
        by_d     = by_q;
        wr_ena_d = 1'b0;
        addr_d   = addr_q;
        data_d   = '0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stamps only start on a tick, so at most one per tick.
                if (tick && btn_place_i) begin
                    sx_d    = cursor_x_q;
                    sy_d    = cursor_y_q;
                    bx_d    = '0;
                    by_d    = '0;
                    state_d = REQ;
                end
            end

            // The grant cycle in REQ already writes cell (0,0) so the first
            // write shows up the cycle after grant is first seen.
            REQ, WRITE: begin
                if (grant_i) begin
                    wr_ena_d = 1'b1;
                    addr_d   = cell_addr;
                    data_d   = {DATA_WIDTH{SAND_CELL}};
                    state_d  = WRITE;
                    if (bx_q == B_LAST) begin
                        bx_d = '0;
                        if (by_q == B_LAST) begin
                            state_d = DONE;
                        end else begin
                            by_d = by_q + BW'(1);
                        end
                    end else begin
                        bx_d = bx_q + BW'(1);
                    end
                end
            end

            DONE: begin
                // done_o is registered, so it pulses the cycle after the last
                // write is visible rather than alongside it.
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cursor_x_q <= X_RESET;
            cursor_y_q <= Y_RESET;
            sx_q       <= '0;
            sy_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            wr_ena_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            wr_ena_q   <= wr_ena_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign req_o               = (state_q == REQ) || (state_q == WRITE);
    assign done_o              = done_q;
    assign wr_ram_ena_o        = wr_ena_q;
    assign ram_write_address_o = addr_q;
    assign ram_write_data_o    = data_q;
    assign cursor_x_o          = cursor_x_q;
    assign cursor_y_o          = cursor_y_q;

endmodule : sand_spawner

// File: tb/tb_sand_spawner.sv
// -----------------------------------------------------------------------------
// tb_sand_spawner
// Self-checking bench for sand_spawner (640x480, BRUSH_SIZE=4, MOVE_DIV=4).
// A behavioural model tracks the expected outputs every cycle; directed
// sequences add literal expectations for cursor moves, saturation, stamp
// addresses, grant gaps and reset during a stamp.
// -----------------------------------------------------------------------------
module tb_sand_spawner;

    localparam int COLS  = 640;
    localparam int ROWS  = 480;
    localparam int BRUSH = 4;
    localparam int DIV   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, down, left, right, place, grant;
    logic        req, done, wr;
    logic [18:0] addr;
    logic [0:0]  data;
    logic [9:0]  cx;
    logic [8:0]  cy;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    sand_spawner #(
        .ACTIVE_COLUMNS (COLS),
        .ACTIVE_ROWS    (ROWS),
        .DATA_WIDTH     (1),
        .BRUSH_SIZE     (BRUSH),
        .MOVE_DIV       (DIV)
    ) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .btn_up_i            (up),
        .btn_down_i          (down),
        .btn_left_i          (left),
        .btn_right_i         (right),
        .btn_place_i         (place),
        .grant_i             (grant),
        .req_o               (req),
        .done_o              (done),
        .wr_ram_ena_o        (wr),
        .ram_write_address_o (addr),
        .ram_write_data_o    (data),
        .cursor_x_o          (cx),
        .cursor_y_o          (cy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    // Stamp progress is a cell index k; cell k is (k % BRUSH, k / BRUSH).
    int phase, mx, my, ssx, ssy, k;
    bit busy, fin, t;
    int e_addr;
    bit e_wr, e_data, e_req, e_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0; mx = COLS / 2; my = ROWS / 2;
            busy = 0; fin = 0; k = 0; ssx = 0; ssy = 0;
            e_wr = 0; e_addr = 0; e_data = 0; e_req = 0; e_done = 0;
        end else begin
            t     = (phase == DIV - 1);
            phase = (phase + 1) % DIV;
            e_wr = 0; e_data = 0; e_done = 0;
            if (fin) begin
                fin = 0;
                e_done = 1;
            end else if (busy) begin
                if (grant) begin
                    e_wr   = 1;
                    e_data = 1;
                    e_addr = (ssy + k / BRUSH) * COLS + ssx + k % BRUSH;
                    k++;
                    if (k == BRUSH * BRUSH) begin
                        busy = 0;
                        fin  = 1;
                    end
                end
            end else if (t && place) begin
                busy = 1; k = 0; ssx = mx; ssy = my;
            end
            e_req = busy;
            if (t) begin
                if (right && !left && mx < COLS - BRUSH) mx++;
                else if (left && !right && mx > 0)       mx--;
                if (down && !up && my < ROWS - BRUSH)    my++;
                else if (up && !down && my > 0)          my--;
            end
        end
    end

    // ------------------------------------------------- compare + monitor
    int log_q[$];
    int n_done;

    always @(negedge clk) begin
        if (checking) begin
            check("cursor_x", 32'(cx), 32'(mx));
            check("cursor_y", 32'(cy), 32'(my));
            check("req", 32'(req), 32'(e_req));
            check("done", 32'(done), 32'(e_done));
            check("wr_ena", 32'(wr), 32'(e_wr));
            check("addr", 32'(addr), 32'(e_addr));
            check("data", 32'(data), 32'(e_data));
            if (wr === 1'b1) log_q.push_back(int'(addr));
            if (done === 1'b1) n_done++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        log_q.delete();
        n_done = 0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("req_seen", 32'(req), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n_done == 0 && n < 80) begin
            step();
            n++;
        end
        check("done_seen", 32'(n_done), 32'd1);
    endtask

    initial begin
        bit seen[int];
        rst = 1'b1;
        {up, down, left, right, place, grant} = '0;
        n_done = 0;
        step();
        step();
        rst = 1'b0;
        checking = 1'b1;

        // Reset state
        check("rst_x", 32'(cx), 32'd320);
        check("rst_y", 32'(cy), 32'd240);
        check("rst_req", 32'(req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);

        // Three ticks right
        right = 1'b1;
        repeat (3 * DIV) step();
        right = 1'b0;
        check("right3_x", 32'(cx), 32'd323);

        // Opposing buttons cancel
        left = 1'b1; right = 1'b1;
        repeat (2 * DIV) step();
        left = 1'b0; right = 1'b0;
        check("lr_x", 32'(cx), 32'd323);

        // Left saturation
        left = 1'b1;
        repeat (330 * DIV) step();
        left = 1'b0;
        check("left_sat_x", 32'(cx), 32'd0);

        // Far edge saturation
        right = 1'b1; down = 1'b1;
        repeat (640 * DIV) step();
        right = 1'b0; down = 1'b0;
        check("right_sat_x", 32'(cx), 32'd636);
        check("down_sat_y", 32'(cy), 32'd476);

        // Full stamp at (320,240), grant held
        do_reset();
        grant = 1'b1; place = 1'b1;
        wait_req();
        place = 1'b0;
        wait_done();
        repeat (4) step();
        check("stamp_writes", 32'(log_q.size()), 32'd16);
        if (log_q.size() == 16) begin
            check("stamp_a0", 32'(log_q[0]), 32'd153920);
            check("stamp_a3", 32'(log_q[3]), 32'd153923);
            check("stamp_a4", 32'(log_q[4]), 32'd154560);
            check("stamp_a15", 32'(log_q[15]), 32'd155843);
        end
        check("stamp_dones", 32'(n_done), 32'd1);
        grant = 1'b0;

        // Grant gap after five writes
        do_reset();
        place = 1'b1;
        wait_req();
        place = 1'b0;
        grant = 1'b1;
        begin
            int n = 0;
            while (log_q.size() < 5 && n < 40) begin
                step();
                n++;
            end
        end
        grant = 1'b0;
        repeat (3) step();
        check("gap_writes", 32'(log_q.size()), 32'd5);
        grant = 1'b1;
        wait_done();
        grant = 1'b0;
        repeat (4) step();
        check("gap_total", 32'(log_q.size()), 32'd16);
        if (log_q.size() > 5) check("gap_resume", 32'(log_q[5]), 32'd154561);
        foreach (log_q[i]) seen[log_q[i]] = 1'b1;
        check("gap_distinct", 32'(seen.num()), 32'd16);

        // Reset in the middle of WRITE
        do_reset();
        grant = 1'b1; place = 1'b1;
        wait_req();
        place = 1'b0;
        begin
            int n = 0;
            while (log_q.size() < 6 && n < 40) begin
                step();
                n++;
            end
        end
        rst = 1'b1;
        #1;
        check("arst_wr", 32'(wr), 32'd0);
        check("arst_req", 32'(req), 32'd0);
        check("arst_x", 32'(cx), 32'd320);
        check("arst_y", 32'(cy), 32'd240);
        step();
        rst = 1'b0;
        n_done = 0;
        repeat (30) step();
        check("arst_no_done", 32'(n_done), 32'd0);
        check("arst_partial", 32'(log_q.size()), 32'd6);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sand_spawner
